seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the shared 7-segment bus on the FPGA_NUM digit group. Holds one BCD value per digit, drives a one-hot active-low scan select, and decodes the selected digit onto the DP/a–g segment lines. A dead-time blanking gap precedes each digit. New values arrive through a valid/ready handshake and are committed only at frame boundaries, so a frame never mixes old and new data.

## Interface
- `DIGITS`, 2: number of scanned digits, 1–8.
- `SCAN_DIV`, 50000: clock cycles per digit slot (blank + show). Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 16: dead-time cycles at the start of each slot, at least 1.

- `clk`  in  1  system clock; the block uses a single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wr_valid`  in  1  new display data offered.
- `wr_ready`  out  1  pending buffer empty; a write is accepted on `wr_valid & wr_ready` at a rising edge.
- `wr_data`  in  4*DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is the rightmost.
- `wr_dp`  in  DIGITS  decimal point per digit, active high.
- `lz_en`  in  1  leading-zero suppression enable; sampled live.
- `scan_select`  out  DIGITS  one-hot active-low digit enable; for DIGITS=2, 2'b10 enables digit 0.
- `seg7`  out  8  {DP,a,b,c,d,e,f,g}, active high.
- `digit_idx`  out  $clog2(DIGITS) (min 1)  index of the current slot.

## Operation
- **Reset values.**
  - `scan_select` = all ones; `seg7` = 8'h00; `digit_idx` = 0.
  - State = BLANK; slot counter = 0.
  - Display registers = 0; DP registers = 0; pending buffer empty, so `wr_ready` = 1.
- **Reset mid-operation.** Asynchronous clear to the values above. Any pending data is discarded.
- **State machine.** Each slot lasts `SCAN_DIV` cycles.
  - BLANK: lasts `BLANK_CYCLES` cycles. `scan_select` is all ones and `seg7` = 0. Then go to SHOW.
  - SHOW: lasts `SCAN_DIV-BLANK_CYCLES` cycles. `scan_select[digit_idx]` = 0 and `seg7` = decode of the current digit. Then go to BLANK and set `digit_idx` = (`digit_idx`+1) mod `DIGITS`.
- **Write path.**
  - A handshake loads `wr_data` and `wr_dp` into the pending buffer and marks it full.
  - `wr_ready` = !pending_full, driven from a register.
- **Commit.**
  - Commit happens on the last SHOW cycle of digit `DIGITS-1`, i.e. on the wrap to 0, and only if pending is full.
  - At commit, the pending buffer copies into the display registers and pending is cleared.
  - The new values first appear in the SHOW phase of digit 0.
  - Commit and accept can never coincide, because `wr_ready` is 0 whenever pending is full.
- **Decode** (DP bit7 from the DP register):
  - 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B.
  - Values 10–15 display a minus sign (g only, 01).
- **Leading-zero suppression.**
  - When `lz_en`=1, digit i is blanked (a–g = 0) if i>0, its value is 0, and every digit above i is 0.
  - Digit 0 is never suppressed.
  - DP still shows on a suppressed digit.
- **Single digit.** With `DIGITS`=1, `digit_idx` stays 0 and every slot end is a frame boundary.

## Timing
- `scan_select`, `seg7` and `digit_idx` are registered and change on the same edge; there is no combinational path from the inputs.
- After `rst_n` deasserts, the first `BLANK_CYCLES` edges stay in BLANK. The next edge drives digit 0 active.
- Frame period = `DIGITS*SCAN_DIV` cycles.
- Worst-case latency from accept to display = `DIGITS*SCAN_DIV + BLANK_CYCLES` + 1 cycles.
- `wr_ready` returns to 1 on the edge after commit.
- `lz_en` and the decode read the display registers in the cycle they are used; changing `lz_en` takes effect at the next SHOW cycle.
- Two scan_select bits are never low at the same time. There is always at least 1 all-high cycle between digits.

## Test plan
All scenarios use `DIGITS`=2, `SCAN_DIV`=8, `BLANK_CYCLES`=2.
- **Reset and scan sequence.** Hold reset, then release. Expect `scan_select`=11 and `seg7`=00 for 2 cycles. Then `scan_select`=10 and `seg7`=7E for 6 cycles, 11 for 2 cycles, 01 for 6 cycles, and the pattern repeats.
- **Write and commit.**
  - Write `wr_data`=8'h37, `wr_dp`=01 during digit 0 SHOW. Expect `wr_ready`=0 and the display unchanged until the wrap.
  - Next digit 0 SHOW: `seg7`=F0 (7 with DP). Digit 1 SHOW: `seg7`=79. `wr_ready`=1 one cycle after commit.
- **Back-pressure.** Issue a second `wr_valid` while pending is full. Expect no accept; the data is held off until `wr_ready`=1 and is then accepted.
- **Leading-zero suppression.**
  - Value 8'h05 with `lz_en`=1: digit 1 `seg7`=00, digit 0 `seg7`=5B.
  - With `lz_en`=0: digit 1 `seg7`=7E.
  - Value 8'h00 with `lz_en`=1: digit 0 shows 7E.
- **Invalid BCD.** Nibble 4'hA on digit 0 → `seg7`=01.
- **Reset mid-operation.** Assert `rst_n`=0 during digit 1 SHOW with pending full. Expect immediate `scan_select`=11, `seg7`=00 and `wr_ready`=1. The display shows 0 afterwards; the pending value is never shown.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed 7-segment scan controller with dead-time blanking,
//            frame-aligned data commit and leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int DIGITS       = 2,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     scan_select,
    output logic [7:0]            seg7,
    output logic [IW-1:0]         digit_idx
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx_nxt;

    logic [3:0]          r_disp [DIGITS];
    logic [DIGITS-1:0]   r_dp;
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_wr_ready;

    logic [DIGITS-1:0]   r_scan_select;
    logic [7:0]          r_seg7;
    logic [IW-1:0]       r_digit_idx;

    logic                w_last_digit;
    logic                w_slot_end;
    logic                w_commit;
    logic                w_accept;
    logic [DIGITS-1:0]   w_zero_up;
    logic                w_run;
    logic                w_suppress;
    logic [7:0]          w_seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h7E;
            4'd1:    decode = 7'h30;
            4'd2:    decode = 7'h6D;
            4'd3:    decode = 7'h79;
            4'd4:    decode = 7'h33;
            4'd5:    decode = 7'h5B;
            4'd6:    decode = 7'h5F;
            4'd7:    decode = 7'h70;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h7B;
            default: decode = 7'h01;
        endcase
    endfunction

    assign w_last_digit = (r_idx == IW'(DIGITS - 1));
    assign w_slot_end   = (r_state == ST_SHOW) && (r_cnt == CW'(SCAN_DIV - 1));
    // Pending data only lands on the frame boundary so a frame is never mixed
    assign w_commit     = w_slot_end && w_last_digit && !r_wr_ready;
    assign w_accept     = wr_valid && r_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CW'(BLANK_CYCLES - 1))
                    w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (r_cnt == CW'(SCAN_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = w_last_digit ? '0 : r_idx + IW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // w_zero_up[i]: digit i and every digit above it hold zero
    always_comb begin
        w_zero_up = '0;
        w_run     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run        = w_run && (r_disp[i] == 4'd0);
            w_zero_up[i] = w_run;
        end
    end

    assign w_suppress = lz_en && (r_idx != '0) && w_zero_up[r_idx];
    assign w_seg      = {r_dp[r_idx], w_suppress ? 7'h00 : decode(r_disp[r_idx])};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_select <= '1;
            r_seg7        <= 8'h00;
            r_digit_idx   <= '0;
        end else begin
            r_digit_idx <= r_idx;
            if (r_state == ST_SHOW) begin
                r_scan_select <= ~(DIGITS'(1) << r_idx);
                r_seg7        <= w_seg;
            end else begin
                r_scan_select <= '1;
                r_seg7        <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++)
                r_disp[i] <= 4'd0;
            r_dp        <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_wr_ready  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_pend_data <= wr_data;
                r_pend_dp   <= wr_dp;
                r_wr_ready  <= 1'b0;
            end
            if (w_commit) begin
                for (int i = 0; i < DIGITS; i++)
                    r_disp[i] <= r_pend_data[4*i +: 4];
                r_dp       <= r_pend_dp;
                r_wr_ready <= 1'b1;
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign scan_select = r_scan_select;
    assign seg7        = r_seg7;
    assign digit_idx   = r_digit_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Directed self-checking bench for seg7_scan_ctrl (2 digits, 8/2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic [1:0] wr_dp;
    logic       lz_en;
    logic [1:0] scan_select;
    logic [7:0] seg7;
    logic [0:0] digit_idx;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_ready;

    seg7_scan_ctrl #(
        .DIGITS       (2),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .lz_en       (lz_en),
        .scan_select (scan_select),
        .seg7        (seg7),
        .digit_idx   (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
        end
    endtask

    // One 16-cycle frame: pos 1-2 blank, 3-8 digit 0, 9-10 blank, 11-16 digit 1.
    // wa/wb raise wr_valid after that position's sample; it drops once accepted.
    task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1,
                             input int wa, input logic [7:0] da, input logic [1:0] pa,
                             input int wb, input logic [7:0] db, input logic [1:0] pb,
                             input int last);
        for (int pos = 1; pos <= last; pos++) begin
            logic       acc;
            logic       com;
            logic [1:0] e_sel;
            logic [7:0] e_seg;
            acc = wr_valid && exp_ready;
            com = (pos == 16) && !exp_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_ready = 1'b0;
                wr_valid  = 1'b0;
            end
            if (com)
                exp_ready = 1'b1;
            if (pos >= 3 && pos <= 8) begin
                e_sel = 2'b10;
                e_seg = e0;
            end else if (pos >= 11) begin
                e_sel = 2'b01;
                e_seg = e1;
            end else begin
                e_sel = 2'b11;
                e_seg = 8'h00;
            end
            check("scan_select", 8'(scan_select), 8'(e_sel));
            check("seg7", seg7, e_seg);
            check("digit_idx", 8'(digit_idx), (pos >= 9) ? 8'd1 : 8'd0);
            check("wr_ready", 8'(wr_ready), 8'(exp_ready));
            if (pos == wa) begin
                wr_valid = 1'b1;
                wr_data  = da;
                wr_dp    = pa;
            end
            if (pos == wb) begin
                wr_valid = 1'b1;
                wr_data  = db;
                wr_dp    = pb;
            end
        end
    endtask

    task automatic check_reset_state();
        check("rst_scan_select", 8'(scan_select), 8'h03);
        check("rst_seg7", seg7, 8'h00);
        check("rst_digit_idx", 8'(digit_idx), 8'h00);
        check("rst_wr_ready", 8'(wr_ready), 8'h01);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        wr_dp     = 2'b00;
        lz_en     = 1'b0;
        exp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up scan with zeroed display
        run_frame(8'h7E, 8'h7E, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);
        // Write 37/dp0 in digit 0 SHOW, then a second write held off by back-pressure
        run_frame(8'h7E, 8'h7E, 4, 8'h37, 2'b01, 8, 8'h05, 2'b00, 16);
        run_frame(8'hF0, 8'h79, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);
        // 05 with suppression on, then off; stage 00 with digit-1 DP
        lz_en = 1'b1;
        run_frame(8'h5B, 8'h00, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);
        lz_en = 1'b0;
        run_frame(8'h5B, 8'h7E, 4, 8'h00, 2'b10, 0, 8'h00, 2'b00, 16);
        // All-zero value: digit 0 never blanked, DP survives on the blanked digit
        lz_en = 1'b1;
        run_frame(8'h7E, 8'h80, 4, 8'h1A, 2'b10, 0, 8'h00, 2'b00, 16);
        // Invalid BCD on digit 0, non-zero digit 1 not suppressed
        run_frame(8'h01, 8'hB0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);
        // Fill pending, then reset during digit 1 SHOW
        run_frame(8'h01, 8'hB0, 4, 8'h09, 2'b11, 0, 8'h00, 2'b00, 12);
        rst_n     = 1'b0;
        exp_ready = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        lz_en = 1'b0;
        // Pending value from before reset must never appear
        run_frame(8'h7E, 8'h7E, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);
        run_frame(8'h7E, 8'h7E, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
